// File: rtl/bdma_steal_arb_pkg.sv
// Shared definitions for the BDMA bus-steal responder: FSM encoding,
// bus-select bit positions and the request-to-bus priority decode.
package bdma_steal_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARB   = 2'd1,
    ST_STEAL = 2'd2,
    ST_COOL  = 2'd3
  } state_t;

  // Bit positions inside the 3-bit one-hot bus-select vector
  localparam int SEL_DM = 0;
  localparam int SEL_PM = 1;
  localparam int SEL_CM = 2;
  localparam int SEL_W  = 3;

  // Priority CM > PM > DM; a request naming no bus falls back to DM
  function automatic logic [SEL_W-1:0] sel_decode(input logic cm, input logic pm, input logic dm);
    logic [SEL_W-1:0] s;
    s = '0;
    if (cm)      s[SEL_CM] = 1'b1;
    else if (pm) s[SEL_PM] = 1'b1;
    else if (dm) s[SEL_DM] = 1'b1;
    else         s[SEL_DM] = 1'b1;
    return s;
  endfunction

endpackage

// File: rtl/bdma_steal_arb_if.sv
// Steal handshake and bus-select bundle between the BDMA/core side (master)
// and the steal arbiter (slave).
interface bdma_steal_arb_if;

  logic BSreq;
  logic BCM_cyc;
  logic BPM_cyc;
  logic BDM_cyc;
  logic CORE_PMreq;
  logic CORE_DMreq;
  logic BOOT;

  logic BSreqx;
  logic GO_STEAL;
  logic BSack;
  logic STL_CM;
  logic STL_PM;
  logic STL_DM;
  logic CORE_STALL;
  logic FORCED;

  modport master (
    output BSreq, BCM_cyc, BPM_cyc, BDM_cyc, CORE_PMreq, CORE_DMreq, BOOT,
    input  BSreqx, GO_STEAL, BSack, STL_CM, STL_PM, STL_DM, CORE_STALL, FORCED
  );

  modport slave (
    input  BSreq, BCM_cyc, BPM_cyc, BDM_cyc, CORE_PMreq, CORE_DMreq, BOOT,
    output BSreqx, GO_STEAL, BSack, STL_CM, STL_PM, STL_DM, CORE_STALL, FORCED
  );

endinterface

// File: rtl/bdma_steal_arb_steal_cnt.sv
// 4-bit up-counter with synchronous clear, saturation at a limit and a
// terminal-count flag; used for both the defer and the hold timers.
module steal_cnt (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_clr,
  input  logic       i_en,
  input  logic [3:0] i_max,
  output logic       o_tc
);

  logic [3:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != i_max)) begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

  assign o_tc = (r_cnt == i_max);

endmodule

// File: rtl/bdma_steal_arb.sv
// Bus-steal responder: arbitrates the BDMA steal request against core
// PM/DM traffic, defers a bounded number of cycles, then opens a steal window.
module bdma_steal_arb
  import bdma_steal_arb_pkg::*;
#(
  parameter int MAX_DEFER = 4,
  parameter int HOLD_CYC  = 1
) (
  input logic              DSPCLK,
  input logic              T_RSTn,
  bdma_steal_arb_if.slave  bus
);

  localparam int CNT_DEFER = 0;
  localparam int CNT_HOLD  = 1;
  localparam logic [3:0] DEFER_LIM = 4'(MAX_DEFER);
  localparam logic [3:0] HOLD_LIM  = 4'(HOLD_CYC - 1);

  state_t           r_state;
  logic             r_bsreqx;
  logic [SEL_W-1:0] r_sel;
  logic             r_forced;

  logic [1:0] w_clr;
  logic [1:0] w_en;
  logic [1:0] w_tc;
  logic [3:0] w_lim [2];
  logic       w_tgt_busy;
  logic       w_free;
  logic       w_go;

  // CM and PM transfers both contend with the core on the PM bus
  assign w_tgt_busy = r_sel[SEL_DM] ? bus.CORE_DMreq : bus.CORE_PMreq;
  assign w_free     = bus.BOOT | ~w_tgt_busy;

  assign w_clr[CNT_DEFER] = (r_state == ST_IDLE);
  assign w_en[CNT_DEFER]  = (r_state == ST_ARB);
  assign w_lim[CNT_DEFER] = DEFER_LIM;
  assign w_clr[CNT_HOLD]  = (r_state != ST_STEAL);
  assign w_en[CNT_HOLD]   = (r_state == ST_STEAL);
  assign w_lim[CNT_HOLD]  = HOLD_LIM;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      steal_cnt u_cnt (
        .clk   (DSPCLK),
        .rst_n (T_RSTn),
        .i_clr (w_clr[gi]),
        .i_en  (w_en[gi]),
        .i_max (w_lim[gi]),
        .o_tc  (w_tc[gi])
      );
    end
  endgenerate

  always_ff @(posedge DSPCLK or negedge T_RSTn) begin
    if (!T_RSTn) begin
      r_state  <= ST_IDLE;
      r_bsreqx <= 1'b0;
      r_sel    <= '0;
      r_forced <= 1'b0;
    end else begin
      r_bsreqx <= bus.BSreq;
      case (r_state)
        ST_IDLE: begin
          if (r_bsreqx) begin
            r_state <= ST_ARB;
            r_sel   <= sel_decode(bus.BCM_cyc, bus.BPM_cyc, bus.BDM_cyc);
          end
        end
        ST_ARB: begin
          if (!r_bsreqx) begin
            r_state <= ST_IDLE;
          end else if (w_free) begin
            r_state  <= ST_STEAL;
            r_forced <= 1'b0;
          end else if (w_tc[CNT_DEFER]) begin
            r_state  <= ST_STEAL;
            r_forced <= 1'b1;
          end
        end
        ST_STEAL: begin
          if (w_tc[CNT_HOLD]) begin
            r_state  <= ST_COOL;
            r_forced <= 1'b0;
          end
        end
        // BSreqx still reflects the request that was just acknowledged
        ST_COOL: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_go = (r_state == ST_STEAL);

  assign bus.BSreqx     = r_bsreqx;
  assign bus.GO_STEAL   = w_go;
  assign bus.BSack      = w_go & w_tc[CNT_HOLD];
  assign bus.STL_CM     = w_go & r_sel[SEL_CM];
  assign bus.STL_PM     = w_go & r_sel[SEL_PM];
  assign bus.STL_DM     = w_go & r_sel[SEL_DM];
  assign bus.CORE_STALL = r_forced;
  assign bus.FORCED     = r_forced;

endmodule

// File: tb/tb_bdma_steal_arb.sv
// Two arbiter instances (MAX_DEFER=4/HOLD_CYC=1 and MAX_DEFER=0/HOLD_CYC=3)
// checked every cycle against a window-countdown model plus pinned scenarios.
module tb_bdma_steal_arb;

  localparam int MD [2] = '{4, 0};
  localparam int HC [2] = '{1, 3};

  logic       clk;
  logic       rst_n;
  int         cyc;
  logic [1:0] bsreq, bcm, bpm, bdm, pmreq, dmreq, boot;
  // {BSreqx, GO_STEAL, BSack, STL_CM, STL_PM, STL_DM, CORE_STALL, FORCED}
  logic [7:0] act [2];

  int n_checks;
  int n_fail;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      bdma_steal_arb_if u_if ();
      assign u_if.BSreq      = bsreq[gi];
      assign u_if.BCM_cyc    = bcm[gi];
      assign u_if.BPM_cyc    = bpm[gi];
      assign u_if.BDM_cyc    = bdm[gi];
      assign u_if.CORE_PMreq = pmreq[gi];
      assign u_if.CORE_DMreq = dmreq[gi];
      assign u_if.BOOT       = boot[gi];
      assign act[gi] = {u_if.BSreqx, u_if.GO_STEAL, u_if.BSack, u_if.STL_CM,
                        u_if.STL_PM, u_if.STL_DM, u_if.CORE_STALL, u_if.FORCED};
      bdma_steal_arb #(.MAX_DEFER(MD[gi]), .HOLD_CYC(HC[gi])) u_dut (
        .DSPCLK (clk),
        .T_RSTn (rst_n),
        .bus    (u_if)
      );
    end
  endgenerate

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Model: a request is "arbitrating" for some number of waited cycles, then
  // a window of HOLD_CYC cycles counts down, followed by one quiet cycle.
  logic       m_x      [2];
  logic       m_arb    [2];
  int         m_wait   [2];
  int         m_left   [2];
  logic       m_cool   [2];
  logic       m_forced [2];
  logic [2:0] m_sel    [2];

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      m_x[i] = 1'b0; m_arb[i] = 1'b0; m_wait[i] = 0; m_left[i] = 0;
      m_cool[i] = 1'b0; m_forced[i] = 1'b0; m_sel[i] = 3'b000;
    end
  endtask

  task automatic model_step(input int i);
    logic busy;
    busy = m_sel[i][0] ? dmreq[i] : pmreq[i];
    if (m_cool[i]) begin
      m_cool[i] = 1'b0;
    end else if (m_left[i] > 0) begin
      m_left[i]--;
      if (m_left[i] == 0) begin
        m_cool[i] = 1'b1;
        m_forced[i] = 1'b0;
      end
    end else if (m_arb[i]) begin
      if (!m_x[i]) begin
        m_arb[i] = 1'b0;
      end else if (boot[i] || !busy) begin
        m_arb[i] = 1'b0; m_left[i] = HC[i]; m_forced[i] = 1'b0;
      end else if (m_wait[i] >= MD[i]) begin
        m_arb[i] = 1'b0; m_left[i] = HC[i]; m_forced[i] = 1'b1;
      end else begin
        m_wait[i]++;
      end
    end else if (m_x[i]) begin
      m_arb[i] = 1'b1;
      m_wait[i] = 0;
      m_sel[i] = bcm[i] ? 3'b100 : (bpm[i] ? 3'b010 : 3'b001);
    end
    m_x[i] = bsreq[i];
  endtask

  function automatic logic [7:0] model_vec(input int i);
    logic go;
    go = (m_left[i] > 0);
    return {m_x[i], go, (m_left[i] == 1), go & m_sel[i][2], go & m_sel[i][1],
            go & m_sel[i][0], go & m_forced[i], go & m_forced[i]};
  endfunction

  initial begin
    model_clear();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_clear();
      else for (int i = 0; i < 2; i++) model_step(i);
    end
  end

  // Hand-computed expectations, pushed ahead of time in cycle order
  int         lit_n;
  int         lit_cyc  [128];
  int         lit_inst [128];
  logic [7:0] lit_mask [128];
  logic [7:0] lit_val  [128];
  string      lit_tag  [128];

  task automatic push(input int inst, input int c, input logic [7:0] mask,
                      input logic [7:0] val, input string tag);
    lit_inst[lit_n] = inst; lit_cyc[lit_n] = c; lit_mask[lit_n] = mask;
    lit_val[lit_n] = val; lit_tag[lit_n] = tag;
    lit_n++;
  endtask

  initial begin
    int rd;
    logic [7:0] exp_v;
    logic [7:0] got;
    n_checks = 0;
    n_fail = 0;
    rd = 0;
    forever begin
      @(negedge clk or negedge rst_n);
      #1;
      for (int i = 0; i < 2; i++) begin
        exp_v = model_vec(i);
        n_checks++;
        if (act[i] !== exp_v) begin
          n_fail++;
          $display("FAIL model inst=%0d cyc=%0d got=%b want=%b", i, cyc, act[i], exp_v);
        end
      end
      if (!clk) begin
        while (rd < lit_n && lit_cyc[rd] <= cyc) begin
          got = act[lit_inst[rd]] & lit_mask[rd];
          n_checks++;
          if (got !== lit_val[rd]) begin
            n_fail++;
            $display("FAIL %s inst=%0d cyc=%0d got=%02h want=%02h mask=%02h",
                     lit_tag[rd], lit_inst[rd], cyc, got, lit_val[rd], lit_mask[rd]);
          end
          rd++;
        end
      end
    end
  end

  initial begin
    int m;
    lit_n = 0;
    rst_n = 1'b0;
    bsreq = '0; bcm = '0; bpm = '0; bdm = '0; pmreq = '0; dmreq = '0; boot = '0;
    repeat (3) @(negedge clk);
    push(0, cyc + 1, 8'hFF, 8'h00, "reset_a");
    push(1, cyc + 1, 8'hFF, 8'h00, "reset_b");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Unobstructed DM steal, BDMA drops BSreq on BSack
    m = cyc; bdm[0] = 1'b1; bsreq[0] = 1'b1;
    push(0, m + 1, 8'h80, 8'h80, "s1_bsreqx");
    push(0, m + 2, 8'h40, 8'h00, "s1_early");
    push(0, m + 3, 8'h7F, 8'h64, "s1_grant");
    push(0, m + 4, 8'hFF, 8'h00, "s1_cool");
    push(0, m + 6, 8'h40, 8'h00, "s1_no_regrant");
    repeat (3) @(negedge clk); bsreq[0] = 1'b0;
    repeat (5) @(negedge clk); bdm[0] = 1'b0;

    // PM busy throughout: forced after MAX_DEFER deferrals
    m = cyc; pmreq[0] = 1'b1; bpm[0] = 1'b1; bsreq[0] = 1'b1;
    push(0, m + 6, 8'h40, 8'h00, "s2_deferred");
    push(0, m + 7, 8'h7F, 8'h6B, "s2_forced");
    push(0, m + 8, 8'hFF, 8'h00, "s2_cool");
    repeat (7) @(negedge clk); bsreq[0] = 1'b0; pmreq[0] = 1'b0;
    repeat (4) @(negedge clk); bpm[0] = 1'b0;

    // PM released at +5: free grant at +6
    m = cyc; pmreq[0] = 1'b1; bpm[0] = 1'b1; bsreq[0] = 1'b1;
    push(0, m + 5, 8'h40, 8'h00, "s2b_deferred");
    push(0, m + 6, 8'h7F, 8'h68, "s2b_free");
    repeat (5) @(negedge clk); pmreq[0] = 1'b0;
    @(negedge clk); bsreq[0] = 1'b0;
    repeat (4) @(negedge clk); bpm[0] = 1'b0;

    // BOOT bypasses deferral against a busy DM bus
    m = cyc; boot[0] = 1'b1; dmreq[0] = 1'b1; bdm[0] = 1'b1; bsreq[0] = 1'b1;
    push(0, m + 3, 8'h7F, 8'h64, "s3_boot");
    repeat (3) @(negedge clk); bsreq[0] = 1'b0;
    repeat (4) @(negedge clk); boot[0] = 1'b0; dmreq[0] = 1'b0; bdm[0] = 1'b0;

    // HOLD_CYC=3 CM window, BSreq dropped in window cycle 2
    m = cyc; bcm[1] = 1'b1; bsreq[1] = 1'b1;
    push(1, m + 2, 8'h40, 8'h00, "s4_early");
    push(1, m + 3, 8'h7F, 8'h50, "s4_win1");
    push(1, m + 4, 8'h7F, 8'h50, "s4_win2");
    push(1, m + 5, 8'h7F, 8'h70, "s4_win3_ack");
    push(1, m + 6, 8'hFF, 8'h00, "s4_cool");
    repeat (4) @(negedge clk); bsreq[1] = 1'b0;
    repeat (4) @(negedge clk); bcm[1] = 1'b0;

    // MAX_DEFER=0: busy DM pre-empted at once
    m = cyc; dmreq[1] = 1'b1; bdm[1] = 1'b1; bsreq[1] = 1'b1;
    push(1, m + 2, 8'h40, 8'h00, "s5_early");
    push(1, m + 3, 8'h7F, 8'h47, "s5_forced");
    push(1, m + 5, 8'h7F, 8'h67, "s5_forced_ack");
    repeat (5) @(negedge clk); bsreq[1] = 1'b0;
    repeat (4) @(negedge clk); dmreq[1] = 1'b0; bdm[1] = 1'b0;

    // Back-to-back: re-raise one cycle after BSack
    m = cyc; bdm[0] = 1'b1; bsreq[0] = 1'b1;
    push(0, m + 3, 8'h7F, 8'h64, "s6_ack1");
    push(0, m + 4, 8'h40, 8'h00, "s6_gap_cool");
    push(0, m + 5, 8'h40, 8'h00, "s6_gap_idle");
    push(0, m + 6, 8'h40, 8'h00, "s6_gap_arb");
    push(0, m + 7, 8'h7F, 8'h64, "s6_ack2");
    repeat (3) @(negedge clk); bsreq[0] = 1'b0;
    @(negedge clk); bsreq[0] = 1'b1;
    repeat (3) @(negedge clk); bsreq[0] = 1'b0;
    repeat (4) @(negedge clk); bdm[0] = 1'b0;

    // Asynchronous reset in the middle of a 3-cycle window
    m = cyc; bdm[1] = 1'b1; bsreq[1] = 1'b1;
    push(1, m + 3, 8'h7F, 8'h44, "s7_window");
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2;
    push(1, cyc, 8'hFF, 8'h00, "s7_in_reset");
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m = cyc;
    push(1, m + 2, 8'h40, 8'h00, "s7_restart_wait");
    push(1, m + 3, 8'h7F, 8'h44, "s7_regrant");
    repeat (5) @(negedge clk); bsreq[1] = 1'b0;
    repeat (4) @(negedge clk); bdm[1] = 1'b0;

    // Randomized BDMA/core traffic
    repeat (3000) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (bsreq[i]) begin
          if (act[i][5]) bsreq[i] = 1'b0;
          else if ($urandom_range(0, 31) == 0) bsreq[i] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          bsreq[i] = 1'b1;
          {bcm[i], bpm[i], bdm[i]} = 3'($urandom_range(0, 7));
        end
        pmreq[i] = ($urandom_range(0, 2) != 0);
        dmreq[i] = ($urandom_range(0, 2) != 0);
        boot[i]  = ($urandom_range(0, 15) == 0);
      end
    end
    bsreq = '0; pmreq = '0; dmreq = '0; boot = '0;
    repeat (10) @(negedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
